// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and helpers for the branch predict unit:
// funct3 encodings, 2-bit counter states and the saturating update.
package branch_pkg;

  // Branch condition encodings (funct3 field)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // 2-bit saturating counter states
  localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

  // Move the counter one step toward the observed outcome, clamping at the ends.
  function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    end else begin
      nxt = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Bus between the pipeline (fetch lookup + execute resolve) and the predict unit.
// master = pipeline side, slave = branch_predict_unit.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  // Fetch-side lookup
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  // Execute-side resolution
  logic            res_valid;
  logic [XLEN-1:0] res_pc;
  logic [2:0]      res_funct3;
  logic [XLEN-1:0] res_rs1;
  logic [XLEN-1:0] res_rs2;
  logic            res_pred_taken;
  // Registered resolution results
  logic            out_valid;
  logic            out_taken;
  logic            out_mispredict;
  logic            out_illegal;
  // Statistics
  logic            stat_clear;
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;

  modport master (
    output pred_pc, res_valid, res_pc, res_funct3, res_rs1, res_rs2,
           res_pred_taken, stat_clear,
    input  pred_taken, out_valid, out_taken, out_mispredict, out_illegal,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  pred_pc, res_valid, res_pc, res_funct3, res_rs1, res_rs2,
           res_pred_taken, stat_clear,
    output pred_taken, out_valid, out_taken, out_mispredict, out_illegal,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_cond.sv
// Combinational branch comparator: evaluates the funct3 condition on a/b
// and flags the two unused encodings (010, 011) as illegal.
module branch_cond
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            taken_o,
  output logic            illegal_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (a_i == b_i);
  assign lt_s = ($signed(a_i) < $signed(b_i));
  assign lt_u = (a_i < b_i);

  // Select the condition; illegal encodings never report taken.
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = ~eq;
      F3_BLT:  taken_o = lt_s;
      F3_BGE:  taken_o = ~lt_s;
      F3_BLTU: taken_o = lt_u;
      F3_BGEU: taken_o = ~lt_u;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped table of 2-bit counters looked up
// combinationally by fetch, updated by execute resolutions, with registered
// resolution results and wrap-around statistics counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CNT_INIT  = CNT_WNT
) (
  input logic                clk,
  input logic                rst,
  branch_predict_unit_if.slave bus
);

  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;

  logic cond_taken;
  logic cond_illegal;
  logic res_legal;

  logic out_valid_q,      out_valid_d;
  logic out_taken_q,      out_taken_d;
  logic out_mispredict_q, out_mispredict_d;
  logic out_illegal_q,    out_illegal_d;

  logic [31:0] stat_branches_q,    stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Word-aligned PCs: the two low bits and everything above the index are not used.
  assign pred_idx = bus.pred_pc[IDX_W+1:2];
  assign res_idx  = bus.res_pc[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc[XLEN-1:IDX_W+2], bus.pred_pc[1:0],
                            bus.res_pc[XLEN-1:IDX_W+2],  bus.res_pc[1:0]};

  // Prediction is the counter MSB, i.e. state weakly-taken or above.
  assign bus.pred_taken = (bht_q[pred_idx] >= CNT_WT);

  branch_cond #(
    .XLEN(XLEN)
  ) u_cond (
    .funct3_i (bus.res_funct3),
    .a_i      (bus.res_rs1),
    .b_i      (bus.res_rs2),
    .taken_o  (cond_taken),
    .illegal_o(cond_illegal)
  );

  assign res_legal = bus.res_valid & ~cond_illegal;

  // Counter table: only a legal resolve trains its entry. The lookup reads the
  // register, so a same-cycle lookup sees the pre-update value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= CNT_INIT;
      end
    end else if (res_legal) begin
      bht_q[res_idx] <= cnt_update(bht_q[res_idx], cond_taken);
    end
  end

  // Next-state for the resolution result registers and statistics.
  always_comb begin
    out_valid_d        = bus.res_valid;
    out_taken_d        = res_legal & cond_taken;
    out_mispredict_d   = res_legal & (cond_taken ^ bus.res_pred_taken);
    out_illegal_d      = bus.res_valid & cond_illegal;
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (bus.stat_clear) begin
      // Clear wins: an event resolving in this cycle is dropped from the stats.
      stat_branches_d    = 32'd0;
      stat_mispredicts_d = 32'd0;
    end else if (res_legal) begin
      stat_branches_d    = stat_branches_q + 32'd1;
      stat_mispredicts_d = stat_mispredicts_q + {31'd0, out_mispredict_d};
    end
  end

  // Result and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q        <= 1'b0;
      out_taken_q        <= 1'b0;
      out_mispredict_q   <= 1'b0;
      out_illegal_q      <= 1'b0;
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      out_valid_q        <= out_valid_d;
      out_taken_q        <= out_taken_d;
      out_mispredict_q   <= out_mispredict_d;
      out_illegal_q      <= out_illegal_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign bus.out_valid        = out_valid_q;
  assign bus.out_taken        = out_taken_q;
  assign bus.out_mispredict   = out_mispredict_q;
  assign bus.out_illegal      = out_illegal_q;
  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit: hand-computed vectors per feature.
module tb_branch_predict_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(XLEN)) bus ();

  branch_predict_unit #(
    .XLEN     (XLEN),
    .BHT_DEPTH(DEPTH),
    .CNT_INIT (2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int exp_b = 0;
  int exp_m = 0;

  // Drive helpers (no checking inside).
  task automatic idle_inputs();
    bus.res_valid      = 1'b0;
    bus.res_pc         = '0;
    bus.res_funct3     = 3'b000;
    bus.res_rs1        = '0;
    bus.res_rs2        = '0;
    bus.res_pred_taken = 1'b0;
    bus.stat_clear     = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic p);
    bus.res_valid      = 1'b1;
    bus.res_pc         = pc;
    bus.res_funct3     = f3;
    bus.res_rs1        = a;
    bus.res_rs2        = b;
    bus.res_pred_taken = p;
  endtask

  // Advance one edge and sample 1 time unit later; resolve inputs drop back to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.pred_pc = 32'h100;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    tests++;
    if (bus.pred_taken !== 1'b0) begin
      fails++; $display("FAIL reset_pred_0x100: got %b want 0", bus.pred_taken);
    end
    tests++;
    if ({bus.out_valid, bus.out_taken, bus.out_mispredict, bus.out_illegal} !== 4'b0000) begin
      fails++; $display("FAIL reset_outs: got %b want 0000",
                        {bus.out_valid, bus.out_taken, bus.out_mispredict, bus.out_illegal});
    end
    tests++;
    if (bus.stat_branches !== 32'd0 || bus.stat_mispredicts !== 32'd0) begin
      fails++; $display("FAIL reset_stats: got %0d/%0d want 0/0",
                        bus.stat_branches, bus.stat_mispredicts);
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus.pred_pc = 32'(i * 4);
      #1;
      tests++;
      if (bus.pred_taken !== 1'b0) begin
        fails++; $display("FAIL reset_entry_%0d: got %b want 0", i, bus.pred_taken);
      end
    end
    $display("[TB] reset: all %0d entries looked up", DEPTH);
  endtask

  task automatic test_compare();
    logic [2:0]  f3 [10];
    logic [31:0] ra [10];
    logic [31:0] rb [10];
    logic        pr [10];
    logic        et [10];
    logic        em;
    f3[0] = 3'b100; ra[0] = 32'hFFFF_FFFF; rb[0] = 32'd1;          pr[0] = 1'b0; et[0] = 1'b1; // BLT -1<1
    f3[1] = 3'b110; ra[1] = 32'hFFFF_FFFF; rb[1] = 32'd1;          pr[1] = 1'b0; et[1] = 1'b0; // BLTU
    f3[2] = 3'b000; ra[2] = 32'd5;         rb[2] = 32'd5;          pr[2] = 1'b1; et[2] = 1'b1; // BEQ
    f3[3] = 3'b000; ra[3] = 32'd5;         rb[3] = 32'd6;          pr[3] = 1'b1; et[3] = 1'b0; // BEQ
    f3[4] = 3'b001; ra[4] = 32'd5;         rb[4] = 32'd6;          pr[4] = 1'b0; et[4] = 1'b1; // BNE
    f3[5] = 3'b101; ra[5] = 32'd1;         rb[5] = 32'hFFFF_FFFF;  pr[5] = 1'b1; et[5] = 1'b1; // BGE 1>=-1
    f3[6] = 3'b101; ra[6] = 32'h8000_0000; rb[6] = 32'h7FFF_FFFF;  pr[6] = 1'b1; et[6] = 1'b0; // BGE min<max
    f3[7] = 3'b111; ra[7] = 32'h8000_0000; rb[7] = 32'h7FFF_FFFF;  pr[7] = 1'b0; et[7] = 1'b1; // BGEU
    f3[8] = 3'b110; ra[8] = 32'd7;         rb[8] = 32'd7;          pr[8] = 1'b0; et[8] = 1'b0; // BLTU equal
    f3[9] = 3'b101; ra[9] = 32'd7;         rb[9] = 32'd7;          pr[9] = 1'b0; et[9] = 1'b1; // BGE equal
    for (int i = 0; i < 10; i++) begin
      resolve(32'h0, f3[i], ra[i], rb[i], pr[i]);
      tick();
      em = et[i] ^ pr[i];
      exp_b++;
      if (em) exp_m++;
      $display("[TB] cmp %0d: f3=%b a=%h b=%h pred=%b -> taken=%b mis=%b",
               i, f3[i], ra[i], rb[i], pr[i], bus.out_taken, bus.out_mispredict);
      tests++;
      if ({bus.out_valid, bus.out_taken, bus.out_mispredict, bus.out_illegal} !==
          {1'b1, et[i], em, 1'b0}) begin
        fails++; $display("FAIL cmp_%0d_outs: got %b want %b", i,
                          {bus.out_valid, bus.out_taken, bus.out_mispredict, bus.out_illegal},
                          {1'b1, et[i], em, 1'b0});
      end
      tests++;
      if (bus.stat_branches !== 32'(exp_b) || bus.stat_mispredicts !== 32'(exp_m)) begin
        fails++; $display("FAIL cmp_%0d_stats: got %0d/%0d want %0d/%0d", i,
                          bus.stat_branches, bus.stat_mispredicts, exp_b, exp_m);
      end
    end
  endtask

  task automatic test_bht_train();
    logic [1:0] exp_pred [5];
    exp_pred[0] = 1'b1; exp_pred[1] = 1'b1; exp_pred[2] = 1'b1; // 10, 11, 11
    exp_pred[3] = 1'b1; exp_pred[4] = 1'b0;                     // 10, 01
    bus.pred_pc = 32'h40;
    #1;
    tests++;
    if (bus.pred_taken !== 1'b0) begin
      fails++; $display("FAIL train_initial: got %b want 0", bus.pred_taken);
    end
    for (int i = 0; i < 5; i++) begin
      logic t;
      logic p;
      t = (i < 3);
      p = (i == 0) ? 1'b0 : 1'b1;
      resolve(32'h40, 3'b000, 32'd5, t ? 32'd5 : 32'd6, p);
      tick();
      exp_b++;
      if (t != p) exp_m++;
      bus.pred_pc = 32'h40;
      #1;
      $display("[TB] train %0d: taken=%b pred_taken@0x40=%b", i, t, bus.pred_taken);
      tests++;
      if (bus.pred_taken !== exp_pred[i][0]) begin
        fails++; $display("FAIL train_%0d_pred: got %b want %b", i, bus.pred_taken, exp_pred[i][0]);
      end
      bus.pred_pc = 32'h40 + 32'(4 * DEPTH);
      #1;
      tests++;
      if (bus.pred_taken !== exp_pred[i][0]) begin
        fails++; $display("FAIL train_%0d_alias: got %b want %b", i, bus.pred_taken, exp_pred[i][0]);
      end
    end
    tests++;
    if (bus.stat_branches !== 32'(exp_b) || bus.stat_mispredicts !== 32'(exp_m)) begin
      fails++; $display("FAIL train_stats: got %0d/%0d want %0d/%0d",
                        bus.stat_branches, bus.stat_mispredicts, exp_b, exp_m);
    end
  endtask

  task automatic test_rdw();
    bus.pred_pc = 32'h80;
    resolve(32'h80, 3'b000, 32'd3, 32'd3, 1'b0);
    #1;
    tests++;
    if (bus.pred_taken !== 1'b0) begin
      fails++; $display("FAIL rdw_same_cycle: got %b want 0", bus.pred_taken);
    end
    tick();
    exp_b++; exp_m++;
    $display("[TB] rdw: same-cycle lookup/update at 0x80, pred after edge=%b", bus.pred_taken);
    tests++;
    if (bus.pred_taken !== 1'b1) begin
      fails++; $display("FAIL rdw_next_cycle: got %b want 1", bus.pred_taken);
    end
  endtask

  task automatic test_illegal();
    // Entry 0x80 is at 10 here.
    for (int i = 0; i < 2; i++) begin
      resolve(32'h80, (i == 0) ? 3'b010 : 3'b011, 32'd3, 32'd3, 1'b1);
      tick();
      $display("[TB] illegal f3=01%0d: valid=%b illegal=%b taken=%b", i,
               bus.out_valid, bus.out_illegal, bus.out_taken);
      tests++;
      if ({bus.out_valid, bus.out_taken, bus.out_mispredict, bus.out_illegal} !== 4'b1001) begin
        fails++; $display("FAIL illegal_%0d_outs: got %b want 1001", i,
                          {bus.out_valid, bus.out_taken, bus.out_mispredict, bus.out_illegal});
      end
      tests++;
      if (bus.stat_branches !== 32'(exp_b) || bus.stat_mispredicts !== 32'(exp_m)) begin
        fails++; $display("FAIL illegal_%0d_stats: got %0d/%0d want %0d/%0d", i,
                          bus.stat_branches, bus.stat_mispredicts, exp_b, exp_m);
      end
      bus.pred_pc = 32'h80;
      #1;
      tests++;
      if (bus.pred_taken !== 1'b1) begin
        fails++; $display("FAIL illegal_%0d_bht: got %b want 1", i, bus.pred_taken);
      end
    end
    // One not-taken step must land on 01 if the illegal resolves left 10 alone.
    resolve(32'h80, 3'b000, 32'd3, 32'd4, 1'b1);
    tick();
    exp_b++; exp_m++;
    #1;
    tests++;
    if (bus.pred_taken !== 1'b0) begin
      fails++; $display("FAIL illegal_bht_after_nt: got %b want 0", bus.pred_taken);
    end
  endtask

  task automatic test_idle();
    tick();
    $display("[TB] idle cycle: valid=%b", bus.out_valid);
    tests++;
    if ({bus.out_valid, bus.out_taken, bus.out_mispredict, bus.out_illegal} !== 4'b0000) begin
      fails++; $display("FAIL idle_outs: got %b want 0000",
                        {bus.out_valid, bus.out_taken, bus.out_mispredict, bus.out_illegal});
    end
    tests++;
    if (bus.stat_branches !== 32'(exp_b) || bus.stat_mispredicts !== 32'(exp_m)) begin
      fails++; $display("FAIL idle_stats: got %0d/%0d want %0d/%0d",
                        bus.stat_branches, bus.stat_mispredicts, exp_b, exp_m);
    end
  endtask

  task automatic test_clear();
    resolve(32'h0, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0);
    bus.stat_clear = 1'b1;
    tick();
    exp_b = 0; exp_m = 0;
    $display("[TB] clear with mispredicting resolve: stats=%0d/%0d mis=%b",
             bus.stat_branches, bus.stat_mispredicts, bus.out_mispredict);
    tests++;
    if (bus.stat_branches !== 32'd0 || bus.stat_mispredicts !== 32'd0) begin
      fails++; $display("FAIL clear_stats: got %0d/%0d want 0/0",
                        bus.stat_branches, bus.stat_mispredicts);
    end
    tests++;
    if (bus.out_mispredict !== 1'b1) begin
      fails++; $display("FAIL clear_out_mis: got %b want 1", bus.out_mispredict);
    end
  endtask

  task automatic test_back_to_back();
    // Entry 0xC0 starts at 01: T, T -> 10, 11; then NT -> 10 keeps predicting taken.
    resolve(32'hC0, 3'b000, 32'd1, 32'd1, 1'b0);
    @(posedge clk);
    #1;
    resolve(32'hC0, 3'b000, 32'd1, 32'd1, 1'b1);
    @(posedge clk);
    #1;
    resolve(32'hC0, 3'b000, 32'd1, 32'd2, 1'b1);
    tick();
    exp_b += 3; exp_m += 2;
    bus.pred_pc = 32'hC0;
    #1;
    $display("[TB] back-to-back T,T,NT at 0xC0: pred=%b stats=%0d/%0d",
             bus.pred_taken, bus.stat_branches, bus.stat_mispredicts);
    tests++;
    if (bus.pred_taken !== 1'b1) begin
      fails++; $display("FAIL b2b_pred: got %b want 1", bus.pred_taken);
    end
    tests++;
    if (bus.stat_branches !== 32'(exp_b) || bus.stat_mispredicts !== 32'(exp_m)) begin
      fails++; $display("FAIL b2b_stats: got %0d/%0d want %0d/%0d",
                        bus.stat_branches, bus.stat_mispredicts, exp_b, exp_m);
    end
  endtask

  task automatic test_async_reset();
    // Entry 0x40 is at 01; train it to 10.
    resolve(32'h40, 3'b000, 32'd9, 32'd9, 1'b0);
    tick();
    bus.pred_pc = 32'h40;
    #1;
    tests++;
    if (bus.pred_taken !== 1'b1 || bus.out_valid !== 1'b1) begin
      fails++; $display("FAIL areset_setup: got pred=%b valid=%b want 1/1",
                        bus.pred_taken, bus.out_valid);
    end
    // Resolve in flight, then assert reset between edges.
    resolve(32'h40, 3'b000, 32'd9, 32'd9, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    $display("[TB] async reset mid-cycle: pred=%b valid=%b stats=%0d/%0d",
             bus.pred_taken, bus.out_valid, bus.stat_branches, bus.stat_mispredicts);
    tests++;
    if (bus.pred_taken !== 1'b0) begin
      fails++; $display("FAIL areset_bht: got %b want 0", bus.pred_taken);
    end
    tests++;
    if ({bus.out_valid, bus.out_taken, bus.out_mispredict, bus.out_illegal} !== 4'b0000) begin
      fails++; $display("FAIL areset_outs: got %b want 0000",
                        {bus.out_valid, bus.out_taken, bus.out_mispredict, bus.out_illegal});
    end
    tests++;
    if (bus.stat_branches !== 32'd0 || bus.stat_mispredicts !== 32'd0) begin
      fails++; $display("FAIL areset_stats: got %0d/%0d want 0/0",
                        bus.stat_branches, bus.stat_mispredicts);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    idle_inputs();
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.stat_branches !== 32'd0 || bus.pred_taken !== 1'b0) begin
      fails++; $display("FAIL areset_discard: got valid=%b branches=%0d pred=%b want 0/0/0",
                        bus.out_valid, bus.stat_branches, bus.pred_taken);
    end
  endtask

  initial begin
    test_reset();
    test_compare();
    test_bht_train();
    test_rdw();
    test_illegal();
    test_idle();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the single-cycle branch condition logic. It combines an XLEN-generic branch comparator with a direct-mapped branch history table (BHT) of 2-bit saturating counters, and reports resolution results and mispredicts one cycle after resolve. It sits between fetch (prediction lookup) and execute (resolution) in the pipelined core, and keeps branch and mispredict statistics counters.

## Interface
Parameters:
- XLEN, 32, operand and PC width
- BHT_DEPTH, 64, number of BHT entries; power of two, minimum 2
- CNT_INIT, 2'b01, reset value of every BHT counter (weakly not-taken)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pred_pc  in  XLEN  fetch PC for lookup
- pred_taken  out  1  combinational prediction: MSB of the indexed counter
- res_valid  in  1  a branch is resolving this cycle
- res_pc  in  XLEN  PC of the resolving branch
- res_funct3  in  3  branch funct3
- res_rs1  in  XLEN  rs1 value
- res_rs2  in  XLEN  rs2 value
- res_pred_taken  in  1  prediction that fetch used for this branch
- out_valid  out  1  registered copy of res_valid
- out_taken  out  1  registered actual outcome
- out_mispredict  out  1  registered: outcome differs from res_pred_taken
- out_illegal  out  1  registered: funct3 is 010 or 011
- stat_clear  in  1  synchronous clear of the statistics counters
- stat_branches  out  32  count of legal resolved branches
- stat_mispredicts  out  32  count of mispredicted legal branches

## Operation
- Index: IDX_W = log2(BHT_DEPTH). idx = pc[IDX_W+1:2]. Bits [1:0] are ignored.
- Conditions: 000 BEQ, 001 BNE, 100 BLT (signed, full XLEN), 101 BGE (signed), 110 BLTU, 111 BGEU. Funct3 010 and 011 are illegal.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Counter update on a legal branch: taken increments, saturating at 11; not-taken decrements, saturating at 00.
- On each edge with res_valid=1 and a legal funct3:
  - update BHT[idx(res_pc)];
  - out_taken = condition;
  - out_mispredict = condition XOR res_pred_taken;
  - stat_branches += 1;
  - stat_mispredicts += out_mispredict.
- Illegal funct3 with res_valid=1:
  - out_valid=1, out_illegal=1, out_taken=0, out_mispredict=0;
  - no BHT update and no stats change.
- res_valid=0: out_valid=0, and out_taken, out_mispredict and out_illegal all read 0 on the next edge.
- Statistics counters wrap modulo 2^32.
- stat_clear takes priority over increments. An event resolving in the clear cycle is not counted.

## Timing
- Prediction latency: zero cycles (combinational read of the BHT).
- Resolution latency: one cycle. Outputs are registered at the edge that samples res_valid.
- Read-during-write, same index: pred_taken shows the pre-update counter. The new value is visible from the cycle after the edge.
- Back-to-back resolves to the same index: each uses the previous edge's updated value, with no lost updates. Sequence from 01: T, T, T gives 10, 11, 11.
- Reset (asynchronous, any time, including mid-resolve):
  - every BHT entry goes to CNT_INIT;
  - out_* go to 0;
  - stat_* go to 0;
  - any in-flight resolution is discarded.
- No backpressure. One resolve per cycle is accepted unconditionally.

## Structure
- Package branch_pkg holds:
  - funct3 constants (F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU);
  - 2-bit counter state constants (CNT_SNT, CNT_WNT, CNT_WT, CNT_ST);
  - a saturating-update function.
- Sub-module branch_cond: combinational, parameter XLEN. Inputs funct3, a, b; outputs taken and illegal.
- Top level holds the BHT register array (flops with asynchronous reset, not RAM), the output registers and the statistics counters.

## Test plan
- Reset, then lookup pred_pc=0x100 -> pred_taken=0. All BHT entries read 01; out_* and stat_* are 0.
- BLT with rs1=0xFFFFFFFF, rs2=1, pred 0 -> next cycle out_taken=1, out_mispredict=1, stat_mispredicts=1. BLTU with the same operands -> out_taken=0.
- Three taken BEQ at pc=0x40 -> counter goes 10, 11, 11. pred_taken at 0x40 is 1 from the cycle after the first edge. Aliasing pc=0x40+4*BHT_DEPTH reads the same entry.
- Same-cycle lookup and update at the same index from state 01 (taken) -> pred_taken=0 that cycle and 1 the next.
- funct3=010 with res_valid=1 -> out_illegal=1, out_taken=0. BHT and stats unchanged.
- stat_clear together with a mispredicting resolve -> both stats are 0 next cycle. Asserting rst mid-stream clears all state asynchronously, before the next clock edge.
